// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and helpers for param_reg_file
//
// Purpose : controller state encoding, default geometry constants and the
//           address-width function used by param_reg_file and its read ports.
// Ports   : none (package).
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_e;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 32;
   localparam int DEF_NRD    = 2;

   // ceil(log2(depth)), never less than one bit
   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read path of param_reg_file
//
// Purpose : selects one array entry and masks it to zero when the array is
//           not ready, the address is out of range, or the address is the
//           hardwired zero entry. With PARAM_REG_FILE_BYPASS_EN defined, a
//           write committed this cycle to the same address is forwarded.
// Ports   : ready_i     - array initialised
//           ra_i        - read address
//           mem_i       - array contents
//           wr_commit_i - a write is being committed this cycle
//           wa_i, wd_i  - address/data of that write
//           rd_o        - read data
// Config  : PARAM_REG_FILE_BYPASS_EN enables same-cycle write forwarding.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ZERO_REG = 1,
   parameter int AW       = addr_width(DEPTH)
) (
   input  logic              ready_i,
   input  logic [AW-1:0]     ra_i,
   input  logic [DATA_W-1:0] mem_i [DEPTH],
   input  logic              wr_commit_i,
   input  logic [AW-1:0]     wa_i,
   input  logic [DATA_W-1:0] wd_i,
   output logic [DATA_W-1:0] rd_o
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic in_range;
   logic is_zero_reg;

   assign in_range    = ({1'b0, ra_i} < DEPTH_W);
   assign is_zero_reg = (ZERO_REG != 0) && (ra_i == '0);

   always_comb begin
      rd_o = '0;
      if (ready_i && in_range && !is_zero_reg) begin
         rd_o = mem_i[ra_i];
`ifdef PARAM_REG_FILE_BYPASS_EN
         // wr_commit_i already excludes dropped writes and the zero entry
         if (wr_commit_i && (wa_i == ra_i)) begin
            rd_o = wd_i;
         end
`endif
      end
   end

`ifndef PARAM_REG_FILE_BYPASS_EN
   logic unused_bypass;
   assign unused_bypass = ^{wr_commit_i, wa_i, wd_i};
`endif

endmodule

// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - parameterised multi-read-port register file
//
// Purpose : DEPTH x DATA_W register array with one write port and NRD
//           combinational read ports. After reset a CLEAR phase zeroes one
//           entry per cycle; ready rises once every entry has been cleared.
//           Writes that cannot be performed raise a one-cycle wr_drop pulse.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           we, wa, wd      - write request, address, data
//           ra, rd          - packed read addresses / read data (NRD ports)
//           ready           - array initialised and accepting writes
//           wr_drop         - previous-cycle write request was not performed
// Config  : PARAM_REG_FILE_BYPASS_EN enables same-cycle write forwarding.
module param_reg_file
   import regfile_pkg::*;
#(
   parameter int   DATA_W   = DEF_DATA_W,
   parameter int   DEPTH    = DEF_DEPTH,
   parameter int   NRD      = DEF_NRD,
   parameter int   ZERO_REG = 1,
   localparam int  AW       = addr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [AW-1:0]         wa,
   input  logic [DATA_W-1:0]     wd,
   input  logic [NRD*AW-1:0]     ra,
   output logic [NRD*DATA_W-1:0] rd,
   output logic                  ready,
   output logic                  wr_drop
);

   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);

   rf_state_e         state_q, state_d;
   logic [AW-1:0]     clr_idx_q, clr_idx_d;
   logic              wr_drop_q, wr_drop_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_commit;

   assign ready   = (state_q == READY);
   assign wr_drop = wr_drop_q;

   // A write taken together with reset is discarded, so forwarding never
   // exposes a value that is not stored.
   assign wr_commit = !rst && we && ready && ({1'b0, wa} < DEPTH_W) &&
                      !((ZERO_REG != 0) && (wa == '0));

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      wr_drop_d = we && !wr_commit;
      if (state_q == CLEAR) begin
         clr_idx_d = clr_idx_q + 1'b1;
         if (clr_idx_q == LAST_IDX) begin
            state_d   = READY;
            clr_idx_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // Array holds its contents while rst is high; the clear sweep follows.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem_q[clr_idx_q] <= '0;
         end else if (wr_commit) begin
            mem_q[wa] <= wd;
         end
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      regfile_read_port #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .ZERO_REG (ZERO_REG),
         .AW       (AW)
      ) u_read_port (
         .ready_i     (ready),
         .ra_i        (ra[g*AW +: AW]),
         .mem_i       (mem_q),
         .wr_commit_i (wr_commit),
         .wa_i        (wa),
         .wd_i        (wd),
         .rd_o        (rd[g*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_param_reg_file.sv
// tb/tb_param_reg_file.sv - self-checking bench for param_reg_file
module tb_param_reg_file;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance: DEPTH=32, two read ports
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic [9:0]  ra = '0;
   logic [63:0] rd;
   logic        ready;
   logic        wr_drop;

   // second instance: DEPTH=24, one read port, for out-of-range addresses
   logic        we2 = 1'b0;
   logic [4:0]  wa2 = '0;
   logic [31:0] wd2 = '0;
   logic [4:0]  ra2 = '0;
   logic [31:0] rd2;
   logic        ready2;
   logic        wr_drop2;

   param_reg_file #(.DATA_W(32), .DEPTH(32), .NRD(2), .ZERO_REG(1)) u_dut (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
      .ra(ra), .rd(rd), .ready(ready), .wr_drop(wr_drop)
   );

   param_reg_file #(.DATA_W(32), .DEPTH(24), .NRD(1), .ZERO_REG(1)) u_dut24 (
      .clk(clk), .rst(rst), .we(we2), .wa(wa2), .wd(wd2),
      .ra(ra2), .rd(rd2), .ready(ready2), .wr_drop(wr_drop2)
   );

   int checks = 0;
   int errors = 0;

   // reference model of the main instance
   logic [31:0] m_mem [32];
   logic        m_ready = 1'b0;
   int          m_left  = 32;
   logic        m_drop  = 1'b0;

   // apply the rules of one rising edge to the model, using current inputs
   task automatic model_edge();
      if (rst) begin
         m_ready = 1'b0;
         m_left  = 32;
         m_drop  = 1'b0;
      end else if (!m_ready) begin
         m_drop = we;
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_ready = 1'b1;
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
         end
      end else if (we && wa != 5'd0) begin
         m_mem[wa] = wd;
         m_drop    = 1'b0;
      end else begin
         m_drop = we;
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (!m_ready || a == 5'd0) return 32'd0;
`ifdef PARAM_REG_FILE_BYPASS_EN
      if (we && !rst && a == wa) return wd;
`endif
      return m_mem[a];
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; we = 1'b0; we2 = 1'b0; ra = {5'd3, 5'd1};
      step();
      step();
      checks++;
      if (ready !== 1'b0 || wr_drop !== 1'b0 || rd !== '0) begin
         errors++;
         $display("FAIL reset_state ready=%b wr_drop=%b rd=%h, expected 0 0 0", ready, wr_drop, rd);
      end
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ra  = 10'($urandom);
         ra2 = 5'($urandom);
         #1;
         checks++;
         if (ready !== m_ready || ready !== 1'b0 || rd !== '0) begin
            errors++;
            $display("FAIL init_clear cycle %0d ready=%b rd=%h, expected 0 0", i, ready, rd);
         end
         checks++;
         if (ready2 !== (i >= 24) || rd2 !== '0) begin
            errors++;
            $display("FAIL init_clear24 cycle %0d ready=%b rd=%h, expected %b 0", i, ready2, rd2, (i >= 24));
         end
         step();
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL init_ready ready=%b, expected 1", ready);
      end
   endtask

   task automatic test_write_readback();
      we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = '0;
      step();
      we = 1'b0; ra = {5'd5, 5'd5};
      #1;
      checks++;
      if (rd[31:0] !== 32'hDEADBEEF || rd[63:32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL readback rd0=%h rd1=%h, expected deadbeef", rd[31:0], rd[63:32]);
      end
      checks++;
      if (wr_drop !== 1'b0) begin
         errors++;
         $display("FAIL readback_drop wr_drop=%b, expected 0", wr_drop);
      end
   endtask

   task automatic test_drop();
      we = 1'b1; wa = 5'd0; wd = 32'h1234; ra = {5'd0, 5'd0};
      #1;
      checks++;
      if (rd !== '0) begin
         errors++;
         $display("FAIL zero_reg_same_cycle rd=%h, expected 0", rd);
      end
      step();
      we = 1'b0;
      #1;
      checks++;
      if (wr_drop !== 1'b1 || rd !== '0) begin
         errors++;
         $display("FAIL zero_reg_drop wr_drop=%b rd=%h, expected 1 0", wr_drop, rd);
      end
      step();
      checks++;
      if (wr_drop !== 1'b0) begin
         errors++;
         $display("FAIL drop_single_pulse wr_drop=%b, expected 0", wr_drop);
      end
      we2 = 1'b1; wa2 = 5'd30; wd2 = 32'hCAFE; ra2 = 5'd30;
      step();
      we2 = 1'b0;
      #1;
      checks++;
      if (wr_drop2 !== 1'b1 || rd2 !== '0) begin
         errors++;
         $display("FAIL out_of_range wr_drop=%b rd=%h, expected 1 0", wr_drop2, rd2);
      end
      we2 = 1'b1; wa2 = 5'd23; wd2 = 32'h77;
      step();
      we2 = 1'b0; ra2 = 5'd23;
      #1;
      checks++;
      if (wr_drop2 !== 1'b0 || rd2 !== 32'h77) begin
         errors++;
         $display("FAIL last_entry24 wr_drop=%b rd=%h, expected 0 77", wr_drop2, rd2);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_same;
      we = 1'b1; wa = 5'd7; wd = 32'h11111111;
      step();
      wd = 32'hA5A5A5A5; ra = {5'd7, 5'd7};
`ifdef PARAM_REG_FILE_BYPASS_EN
      exp_same = 32'hA5A5A5A5;
`else
      exp_same = 32'h11111111;
`endif
      #1;
      checks++;
      if (rd[31:0] !== exp_same || rd[63:32] !== exp_same) begin
         errors++;
         $display("FAIL same_cycle_read rd0=%h rd1=%h, expected %h", rd[31:0], rd[63:32], exp_same);
      end
      step();
      we = 1'b0;
      #1;
      checks++;
      if (rd[31:0] !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL next_cycle_read rd0=%h, expected a5a5a5a5", rd[31:0]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom_range(0, 1));
         wa = 5'($urandom);
         wd = $urandom;
         ra = 10'($urandom);
         if ($urandom_range(0, 3) == 0) ra[4:0] = wa;
         #1;
         checks++;
         if (rd[31:0] !== exp_rd(ra[4:0])) begin
            errors++;
            $display("FAIL random_rd0 iter %0d ra=%0d rd=%h, expected %h", i, ra[4:0], rd[31:0], exp_rd(ra[4:0]));
         end
         checks++;
         if (rd[63:32] !== exp_rd(ra[9:5])) begin
            errors++;
            $display("FAIL random_rd1 iter %0d ra=%0d rd=%h, expected %h", i, ra[9:5], rd[63:32], exp_rd(ra[9:5]));
         end
         step();
         checks++;
         if (wr_drop !== m_drop) begin
            errors++;
            $display("FAIL random_drop iter %0d wr_drop=%b, expected %b", i, wr_drop, m_drop);
         end
      end
      we = 1'b0;
   endtask

   task automatic test_reset_mid_clear();
      int n;
      we = 1'b1; wa = 5'd9; wd = 32'h99999999;
      step();
      wa = 5'd3; wd = 32'h33333333;
      step();
      we = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0; ra = {5'd3, 5'd9};
      for (int i = 0; i < 10; i++) begin
         we = (i == 4); wa = 5'd3; wd = 32'hFFFF;
         #1;
         checks++;
         if (ready !== 1'b0 || rd !== '0) begin
            errors++;
            $display("FAIL clear_masked cycle %0d ready=%b rd=%h, expected 0 0", i, ready, rd);
         end
         step();
         if (i == 4 || i == 5) begin
            checks++;
            if (wr_drop !== (i == 4)) begin
               errors++;
               $display("FAIL clear_write_drop cycle %0d wr_drop=%b, expected %b", i, wr_drop, (i == 4));
            end
         end
      end
      we = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (n != 32 || m_ready !== 1'b1) begin
         errors++;
         $display("FAIL restart_latency cycles=%0d, expected 32", n);
      end
      #1;
      checks++;
      if (rd[31:0] !== 32'd0 || rd[63:32] !== 32'd0) begin
         errors++;
         $display("FAIL cleared_entries rd3=%h rd9=%h, expected 0 0", rd[31:0], rd[63:32]);
      end
   endtask

   initial begin
      test_reset();
      test_write_readback();
      test_drop();
      test_bypass();
      test_random();
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
